ct_spsram_256x54_arb: RTL and testbench
=======================================

# ct_spsram_256x54_arb

Access controller for the 256-entry × 54-bit single-port SRAM macro. It initializes the array after reset or on flush. It then shares the single port between one write requester (refill) and one read requester (lookup), using write priority with a read anti-starvation rule. It sits between the cache-side requesters and the SRAM instance and is the only block that drives the SRAM pins.

## Interface
Parameters:
- `IDX_W`, 8, index width (256 entries)
- `DATA_W`, 54, data width; two 27-bit halves
- `STARVE_MAX`, 3, consecutive blocked read cycles before the read is forced to win

Ports:
- `forever_cpuclk` input 1: clock; also drives the SRAM `CLK`.
- `cpurst_b` input 1: asynchronous active-low reset.
- `flush_req` input 1: one-cycle pulse that restarts the init sweep.
- `wr_req` input 1: write request.
- `wr_idx` input 8: write index.
- `wr_data` input 54: write data.
- `wr_hmask` input 2: half enables; bit0 = [26:0], bit1 = [53:27]; 1 = write.
- `wr_gnt` output 1: write accepted this cycle.
- `rd_req` input 1: read request.
- `rd_idx` input 8: read index.
- `rd_gnt` output 1: read accepted this cycle.
- `rd_vld` output 1: read data valid.
- `rd_data` output 54: read data, held until the next `rd_vld`.
- `busy` output 1: init sweep in progress.
- `sram_a` output 8, `sram_cen` output 1, `sram_gwen` output 1, `sram_wen` output 54, `sram_d` output 54: SRAM pins; CEN, GWEN and WEN are active low.
- `sram_q` input 54: SRAM read data.

## Operation
- FSM states: IDLE, INIT, RUN.
  - Reset enters INIT.
  - INIT → RUN after index 255 is written.
  - RUN → INIT on `flush_req`.
  - IDLE is used only when INIT is compiled out (see Configuration); it passes to RUN on the first cycle.
- INIT:
  - 8-bit counter from 0 to 255, one write per cycle.
  - Drives `sram_cen`=0, `sram_gwen`=0, `sram_wen`=all 0, `sram_d`=0, `sram_a`=counter.
  - `busy`=1. All grants are 0.
  - A `flush_req` during INIT restarts the counter at 0.
- RUN arbitration, combinational in the same cycle:
  - Only `wr_req`: grant write.
  - Only `rd_req`: grant read.
  - Both: write wins unless `starve_cnt == STARVE_MAX`, in which case read wins.
  - A `flush_req` in RUN takes effect next cycle. Any grant issued in the same cycle still completes.
- Starvation counter:
  - 2-bit `starve_cnt` increments when `rd_req`=1 and `rd_gnt`=0 in RUN.
  - Clears on `rd_gnt`, or when `rd_req`=0.
  - Saturates at `STARVE_MAX`.
- Write grant drives:
  - `sram_cen`=0, `sram_gwen`=0.
  - `sram_wen[26:0]` = {27{~wr_hmask[0]}}, `sram_wen[53:27]` = {27{~wr_hmask[1]}}.
  - `sram_d`=`wr_data`, `sram_a`=`wr_idx`.
  - `wr_hmask`=0 is still granted; the SRAM is enabled with all WEN=1, so nothing is written.
- Read grant drives: `sram_cen`=0, `sram_gwen`=1, `sram_wen`=all 1, `sram_a`=`rd_idx`.
- No grant:
  - `sram_cen`=1, `sram_gwen`=1, `sram_wen`=all 1.
  - `sram_a` holds its last value, to avoid toggling; the macro latches the address only when CEN=0.
- Read return:
  - The read-pending flop is set on `rd_gnt`.
  - The next cycle, `rd_data` <= `sram_q` and `rd_vld`=1 for one cycle.
  - `rd_data` is held between returns.
- Read-after-write ordering:
  - A read granted the cycle after a write to the same index returns the new data; the SRAM is write-through-ordered and no forwarding is needed.
  - Writes and reads cannot be granted in the same cycle.

## Timing
- Reset values:
  - `wr_gnt`=0, `rd_gnt`=0, `rd_vld`=0, `rd_data`=0.
  - `busy`=1 (INIT compiled in) or 0 (compiled out).
  - `sram_cen`=1, `sram_gwen`=1, `sram_wen`=all 1, `sram_a`=0, `sram_d`=0.
  - `starve_cnt`=0, init counter=0.
- Init sweep:
  - 256 cycles, starting the first clock after `cpurst_b` rises.
  - `busy` falls after the cycle that writes index 255.
  - The first grant is possible on cycle 257.
- Grant latency: 0 cycles, combinational from request in RUN.
- Read latency: `rd_vld` asserts 1 cycle after `rd_gnt`.
- Throughput: one access per cycle; back-to-back reads give back-to-back `rd_vld`.
- Reset asserted mid-sweep or mid-read:
  - All state clears immediately.
  - A pending `rd_vld` is dropped and the sweep restarts from 0.

## Configuration
- `CT_SPSRAM_ARB_INIT_EN`:
  - Defined: INIT state, counter and `flush_req` handling are present, as above.
  - Undefined: reset enters IDLE and then RUN. `busy` is tied 0 and `flush_req` is ignored. Array contents after reset are undefined; the owner clears valid bits elsewhere.

## Test plan
- Reset release with INIT enabled → 256 writes to indices 0..255 with D=0; `busy` deasserts; `rd_req` to index 0x80 returns `rd_data`=0.
- Write 0x2A_AAAA_5555_555 to index 0x10 with `wr_hmask`=2'b01, then read → only [26:0] updated, [53:27] still 0.
- `wr_req` and `rd_req` held high for 8 cycles → pattern W,W,W,R,W,W,W,R; `rd_vld` one cycle after each R grant.
- Write index 0x33 then read 0x33 on the next cycle → `rd_data` equals the written value, latency 1.
- `flush_req` in RUN while an earlier read is in flight → that `rd_vld` still arrives; `busy` rises next cycle; the full 256-cycle sweep runs.
- `cpurst_b` low at sweep index 100 → outputs return to reset values asynchronously; after release the sweep restarts at 0.

Source files
------------

// File: rtl/ct_spsram_256x54_arb.sv
// ct_spsram_256x54_arb
// Access controller for a 256x54 single-port SRAM macro. Sweeps the array to
// zero after reset / flush, then arbitrates the single port between a write
// requester (priority) and a read requester (forced to win after STARVE_MAX
// consecutive blocked cycles). Grants and SRAM pins are combinational from the
// requests; read data returns one cycle after the read grant.
// Optional feature macro: CT_SPSRAM_ARB_INIT_EN (init sweep + flush_req).
// With the macro undefined, reset enters IDLE, then RUN; busy is tied low.
module ct_spsram_256x54_arb #(
  parameter int IDX_W      = 8,
  parameter int DATA_W     = 54,
  parameter int STARVE_MAX = 3
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              flush_req,
  input  logic              wr_req,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        wr_hmask,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_gnt,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [IDX_W-1:0]  sram_a,
  output logic              sram_cen,
  output logic              sram_gwen,
  output logic [DATA_W-1:0] sram_wen,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  localparam int         HALF_W     = DATA_W / 2;
  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          starve_cnt_q, starve_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [IDX_W-1:0]    a_hold_q, a_hold_d;

`ifdef CT_SPSRAM_ARB_INIT_EN
  localparam state_e RST_STATE = ST_INIT;
  logic [IDX_W-1:0]    init_cnt_q, init_cnt_d;
`else
  localparam state_e RST_STATE = ST_IDLE;
  // flush has no meaning without the sweep; keep it visibly consumed.
  logic                unused_flush;
  assign unused_flush = flush_req;
`endif

  // Next state, sweep counter and same-cycle write-priority arbitration.
  always_comb begin
    state_d = state_q;
    wr_gnt  = 1'b0;
    rd_gnt  = 1'b0;
    busy    = 1'b0;
`ifdef CT_SPSRAM_ARB_INIT_EN
    init_cnt_d = init_cnt_q;
`endif
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
`ifdef CT_SPSRAM_ARB_INIT_EN
      ST_INIT: begin
        busy       = 1'b1;
        init_cnt_d = init_cnt_q + 1'b1;
        if (flush_req) begin
          init_cnt_d = '0;
        end else if (init_cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_RUN: begin
        // A starved read overrides write priority for exactly one grant.
        if (wr_req && !(rd_req && (starve_cnt_q == STARVE_LIM))) begin
          wr_gnt = 1'b1;
        end else if (rd_req) begin
          rd_gnt = 1'b1;
        end
`ifdef CT_SPSRAM_ARB_INIT_EN
        // The grant above still completes; the sweep starts next cycle.
        if (flush_req) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
`endif
      end
      default: state_d = RST_STATE;
    endcase
  end

  // SRAM pin drive; address is parked on its last value when the port is idle.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_d    = '0;
    sram_a    = a_hold_q;
    if (wr_gnt) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = {{HALF_W{~wr_hmask[1]}}, {HALF_W{~wr_hmask[0]}}};
      sram_d    = wr_data;
      sram_a    = wr_idx;
    end else if (rd_gnt) begin
      sram_cen  = 1'b0;
      sram_a    = rd_idx;
    end
`ifdef CT_SPSRAM_ARB_INIT_EN
    // Reset keeps the macro deselected even though the state already reads INIT.
    else if ((state_q == ST_INIT) && cpurst_b) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt_q;
    end
`endif
  end

  // Consecutive blocked-read counter, saturating at the starvation limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!rd_req || rd_gnt) begin
      starve_cnt_d = '0;
    end else if ((state_q == ST_RUN) && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 2'd1;
    end
  end

  // Read return: macro output is presented the cycle after the grant and held.
  always_comb begin
    rd_pend_d = rd_gnt;
    rd_data_d = rd_pend_q ? sram_q : rd_data_q;
    a_hold_d  = sram_a;
  end

  assign rd_vld  = rd_pend_q;
  assign rd_data = rd_data_d;

  // Control and hold registers.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q      <= RST_STATE;
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_data_q    <= '0;
      a_hold_q     <= '0;
`ifdef CT_SPSRAM_ARB_INIT_EN
      init_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_data_q    <= rd_data_d;
      a_hold_q     <= a_hold_d;
`ifdef CT_SPSRAM_ARB_INIT_EN
      init_cnt_q   <= init_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ct_spsram_256x54_arb.sv
// Testbench for ct_spsram_256x54_arb: behavioural SRAM macro plus a
// transaction-level reference model (array contents, blocked-read count,
// pending read) driven with randomized requests.
module tb_ct_spsram_256x54_arb;

  localparam int STARVE_MAX = 3;
  localparam int MODE_IDLE  = 0;
  localparam int MODE_INIT  = 1;
  localparam int MODE_RUN   = 2;
`ifdef CT_SPSRAM_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic        forever_cpuclk;
  logic        cpurst_b;
  logic        flush_req;
  logic        wr_req;
  logic [7:0]  wr_idx;
  logic [53:0] wr_data;
  logic [1:0]  wr_hmask;
  logic        wr_gnt;
  logic        rd_req;
  logic [7:0]  rd_idx;
  logic        rd_gnt;
  logic        rd_vld;
  logic [53:0] rd_data;
  logic        busy;
  logic [7:0]  sram_a;
  logic        sram_cen;
  logic        sram_gwen;
  logic [53:0] sram_wen;
  logic [53:0] sram_d;
  logic [53:0] sram_q;

  ct_spsram_256x54_arb dut (
    .forever_cpuclk(forever_cpuclk), .cpurst_b(cpurst_b), .flush_req(flush_req),
    .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .wr_hmask(wr_hmask),
    .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_idx(rd_idx), .rd_gnt(rd_gnt),
    .rd_vld(rd_vld), .rd_data(rd_data), .busy(busy), .sram_a(sram_a),
    .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_d(sram_d), .sram_q(sram_q)
  );

  initial forever_cpuclk = 1'b0;
  always #5 forever_cpuclk = ~forever_cpuclk;

  // Behavioural single-port macro: bit-masked write, registered read.
  logic [53:0] mem [256];
  logic [53:0] q_r;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    q_r = '0;
  end
  always @(posedge forever_cpuclk) begin
    if (!sram_cen) begin
      if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            q_r <= mem[sram_a];
    end
  end
  assign sram_q = q_r;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state.
  logic [53:0] ref_mem [256];
  int          ref_mode;
  int          ref_sweep;
  int          ref_blocked;
  bit          ref_pend;
  logic [53:0] ref_pend_data;
  logic [53:0] ref_hold;
  logic [7:0]  ref_last_a;

  // Expectations for the cycle just driven.
  logic        exp_wg, exp_rg, exp_vld, exp_busy, exp_cen, exp_gwen;
  logic [7:0]  exp_a;
  logic [53:0] exp_wen, exp_d, exp_rdata;

  initial for (int i = 0; i < 256; i++) ref_mem[i] = '0;

  task automatic model_reset();
    ref_mode    = INIT_EN ? MODE_INIT : MODE_IDLE;
    ref_sweep   = 0;
    ref_blocked = 0;
    ref_pend    = 1'b0;
    ref_hold    = '0;
    ref_last_a  = '0;
  endtask

  // Drive one cycle of requests, form expectations, then advance the model
  // past the coming clock edge. Returns before that edge.
  task automatic run_cycle(input logic wr, input logic [7:0] wi, input logic [53:0] wd,
                           input logic [1:0] wm, input logic rd, input logic [7:0] ri,
                           input logic fl);
    logic [53:0] rdat;
    @(negedge forever_cpuclk);
    flush_req = fl; wr_req = wr; wr_idx = wi; wr_data = wd; wr_hmask = wm;
    rd_req = rd; rd_idx = ri;
    #1;
    cyc++;
    exp_wg = 1'b0; exp_rg = 1'b0; exp_busy = (ref_mode == MODE_INIT);
    exp_cen = 1'b1; exp_gwen = 1'b1; exp_wen = '1; exp_d = '0; exp_a = ref_last_a;
    if (ref_mode == MODE_INIT) begin
      exp_cen = 1'b0; exp_gwen = 1'b0; exp_wen = '0; exp_a = 8'(ref_sweep);
    end else if (ref_mode == MODE_RUN) begin
      if (rd && (!wr || ref_blocked == STARVE_MAX)) exp_rg = 1'b1;
      else if (wr) exp_wg = 1'b1;
      if (exp_wg) begin
        exp_cen = 1'b0; exp_gwen = 1'b0; exp_d = wd; exp_a = wi;
        exp_wen = '1;
        if (wm[0]) exp_wen[26:0]  = '0;
        if (wm[1]) exp_wen[53:27] = '0;
      end
      if (exp_rg) begin
        exp_cen = 1'b0; exp_a = ri;
      end
    end
    exp_vld   = ref_pend;
    exp_rdata = ref_pend ? ref_pend_data : ref_hold;
    // Advance the model.
    rdat = ref_mem[ri];
    if (exp_wg) begin
      if (wm[0]) ref_mem[wi][26:0]  = wd[26:0];
      if (wm[1]) ref_mem[wi][53:27] = wd[53:27];
    end
    if (ref_mode == MODE_INIT) ref_mem[ref_sweep] = '0;
    if (ref_pend) ref_hold = ref_pend_data;
    ref_pend      = exp_rg;
    ref_pend_data = rdat;
    if (!rd || exp_rg) ref_blocked = 0;
    else if (ref_mode == MODE_RUN && ref_blocked < STARVE_MAX) ref_blocked++;
    ref_last_a = exp_a;
    case (ref_mode)
      MODE_IDLE: ref_mode = MODE_RUN;
      MODE_INIT: begin
        if (fl) ref_sweep = 0;
        else if (ref_sweep == 255) ref_mode = MODE_RUN;
        else ref_sweep++;
      end
      default: if (fl && INIT_EN) begin ref_mode = MODE_INIT; ref_sweep = 0; end
    endcase
  endtask

  task automatic test_reset();
    cpurst_b = 1'b0; flush_req = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    wr_idx = 8'h12; rd_idx = 8'h34; wr_data = '1; wr_hmask = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge forever_cpuclk); #1;
      checks++;
      if ({wr_gnt, rd_gnt, rd_vld, busy} !== {1'b0, 1'b0, 1'b0, INIT_EN}) begin
        failures++;
        $display("FAIL reset_ctl got=%b%b%b%b want=000%b", wr_gnt, rd_gnt, rd_vld, busy, INIT_EN);
      end
      checks++;
      if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d, rd_data} !== {2'b11, {54{1'b1}}, 8'h00, 54'h0, 54'h0}) begin
        failures++;
        $display("FAIL reset_pins got cen=%b gwen=%b wen=%h a=%h d=%h rd_data=%h", sram_cen, sram_gwen, sram_wen, sram_a, sram_d, rd_data);
      end
    end
    @(posedge forever_cpuclk); #1;
    cpurst_b = 1'b1;
    model_reset();
  endtask

  task automatic test_init_sweep(input int exp_busy_cycles);
    int n = 0;
    int busy_cycles = 0;
    while (ref_mode != MODE_RUN && n < 300) begin
      run_cycle(1'b1, 8'($urandom), '1, 2'b11, 1'b0, 8'h00, 1'b0);
      n++;
      if (busy === 1'b1) busy_cycles++;
      checks++;
      if ({wr_gnt, rd_gnt, rd_vld, busy} !== {exp_wg, exp_rg, exp_vld, exp_busy}) begin
        failures++;
        $display("FAIL sweep_ctl cyc=%0d got=%b%b%b%b want=%b%b%b%b", cyc, wr_gnt, rd_gnt, rd_vld, busy, exp_wg, exp_rg, exp_vld, exp_busy);
      end
      checks++;
      if ({sram_cen, sram_gwen, sram_a, sram_wen, sram_d} !== {exp_cen, exp_gwen, exp_a, exp_wen, exp_d}) begin
        failures++;
        $display("FAIL sweep_pins cyc=%0d got a=%h cen=%b gwen=%b wen=%h want a=%h cen=%b gwen=%b wen=%h", cyc, sram_a, sram_cen, sram_gwen, sram_wen, exp_a, exp_cen, exp_gwen, exp_wen);
      end
    end
    checks++;
    if (busy_cycles !== exp_busy_cycles || n >= 300) begin
      failures++;
      $display("FAIL sweep_len busy_cycles=%0d want=%0d", busy_cycles, exp_busy_cycles);
    end
  endtask

  task automatic test_read_init();
    run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b1, 8'h80, 1'b0);
    checks++;
    if (rd_gnt !== 1'b1 || sram_a !== 8'h80 || sram_cen !== 1'b0) begin
      failures++;
      $display("FAIL read80_gnt got gnt=%b a=%h cen=%b want 1 80 0", rd_gnt, sram_a, sram_cen);
    end
    run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (rd_vld !== 1'b1 || rd_data !== 54'h0) begin
      failures++;
      $display("FAIL read80_data got vld=%b data=%h want 1 0", rd_vld, rd_data);
    end
  endtask

  task automatic test_half_mask();
    logic [53:0] v;
    logic [53:0] want;
    v    = 54'h2A_AAAA_5555_555;
    want = {27'h0, v[26:0]};
    run_cycle(1'b1, 8'h10, v, 2'b01, 1'b0, 8'h00, 1'b0);
    checks++;
    if (wr_gnt !== 1'b1 || sram_wen !== {{27{1'b1}}, 27'h0} || sram_d !== v) begin
      failures++;
      $display("FAIL hmask_pins got gnt=%b wen=%h d=%h", wr_gnt, sram_wen, sram_d);
    end
    run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b1, 8'h10, 1'b0);
    run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (rd_vld !== 1'b1 || rd_data !== want) begin
      failures++;
      $display("FAIL hmask_data got vld=%b data=%h want 1 %h", rd_vld, rd_data, want);
    end
    checks++;
    if (rd_data !== exp_rdata) begin
      failures++;
      $display("FAIL hmask_model got=%h want=%h", rd_data, exp_rdata);
    end
  endtask

  task automatic test_arb_pattern();
    logic [7:0] rd_at;
    rd_at = 8'b1000_1000;
    run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) begin
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      run_cycle(i < 8, 8'($urandom), r[53:0], 2'($urandom), i < 8, 8'($urandom), 1'b0);
      if (i < 8) begin
        checks++;
        if (rd_gnt !== rd_at[i] || wr_gnt !== ~rd_at[i]) begin
          failures++;
          $display("FAIL arb_pattern slot=%0d got wg=%b rg=%b want rg=%b", i, wr_gnt, rd_gnt, rd_at[i]);
        end
      end
      checks++;
      if ({wr_gnt, rd_gnt, rd_vld, busy} !== {exp_wg, exp_rg, exp_vld, exp_busy} || rd_data !== exp_rdata) begin
        failures++;
        $display("FAIL arb_model cyc=%0d got=%b%b%b%b data=%h want=%b%b%b%b data=%h", cyc, wr_gnt, rd_gnt, rd_vld, busy, rd_data, exp_wg, exp_rg, exp_vld, exp_busy, exp_rdata);
      end
    end
  endtask

  task automatic test_raw();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    run_cycle(1'b1, 8'h33, r[53:0], 2'b11, 1'b0, 8'h00, 1'b0);
    run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b1, 8'h33, 1'b0);
    checks++;
    if (rd_gnt !== 1'b1 || rd_vld !== 1'b0) begin
      failures++;
      $display("FAIL raw_gnt got gnt=%b vld=%b want 1 0", rd_gnt, rd_vld);
    end
    run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (rd_vld !== 1'b1 || rd_data !== r[53:0]) begin
      failures++;
      $display("FAIL raw_data got vld=%b data=%h want 1 %h", rd_vld, rd_data, r[53:0]);
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      run_cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 7)) + 8'hC0, r[53:0],
                2'($urandom), $urandom_range(0, 2) != 0, 8'($urandom_range(0, 7)) + 8'hC0, 1'b0);
      checks++;
      if ({wr_gnt, rd_gnt, rd_vld, busy} !== {exp_wg, exp_rg, exp_vld, exp_busy}) begin
        failures++;
        $display("FAIL rand_ctl cyc=%0d got=%b%b%b%b want=%b%b%b%b", cyc, wr_gnt, rd_gnt, rd_vld, busy, exp_wg, exp_rg, exp_vld, exp_busy);
      end
      checks++;
      if ({sram_cen, sram_gwen, sram_a, sram_wen, sram_d} !== {exp_cen, exp_gwen, exp_a, exp_wen, exp_d}) begin
        failures++;
        $display("FAIL rand_pins cyc=%0d got cen=%b gwen=%b a=%h wen=%h d=%h want cen=%b gwen=%b a=%h wen=%h d=%h", cyc, sram_cen, sram_gwen, sram_a, sram_wen, sram_d, exp_cen, exp_gwen, exp_a, exp_wen, exp_d);
      end
      checks++;
      if (rd_data !== exp_rdata) begin
        failures++;
        $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, rd_data, exp_rdata);
      end
    end
  endtask

  task automatic test_flush();
    logic [53:0] want;
    run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b1, 8'hC5, 1'b0);
    want = ref_pend_data;
    run_cycle(1'b1, 8'h07, 54'h15, 2'b11, 1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_vld !== 1'b1 || rd_data !== want || wr_gnt !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_inflight got vld=%b data=%h wg=%b busy=%b want 1 %h 1 0", rd_vld, rd_data, wr_gnt, busy, want);
    end
    run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (busy !== INIT_EN || sram_cen !== ~INIT_EN) begin
      failures++;
      $display("FAIL flush_busy got busy=%b cen=%b want busy=%b", busy, sram_cen, INIT_EN);
    end
    test_init_sweep(INIT_EN ? 255 : 0);
  endtask

`ifdef CT_SPSRAM_ARB_INIT_EN
  task automatic test_reset_mid_sweep();
    run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i <= 100; i++) run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (sram_a !== 8'd100 || busy !== 1'b1 || sram_cen !== 1'b0) begin
      failures++;
      $display("FAIL midsweep_idx got a=%0d busy=%b cen=%b want 100 1 0", sram_a, busy, sram_cen);
    end
    #2 cpurst_b = 1'b0;
    #1;
    checks++;
    if ({sram_cen, sram_gwen, sram_a, sram_wen, busy, wr_gnt, rd_gnt, rd_vld} !== {2'b11, 8'h00, {54{1'b1}}, 4'b1000}) begin
      failures++;
      $display("FAIL midsweep_reset got cen=%b gwen=%b a=%h wen=%h busy=%b", sram_cen, sram_gwen, sram_a, sram_wen, busy);
    end
    repeat (2) @(posedge forever_cpuclk);
    #1 cpurst_b = 1'b1;
    model_reset();
    test_init_sweep(256);
  endtask
`endif

  task automatic test_reset_mid_read();
    run_cycle(1'b0, 8'h00, '0, 2'b00, 1'b1, 8'h33, 1'b0);
    @(posedge forever_cpuclk); #2;
    checks++;
    if (rd_vld !== 1'b1) begin
      failures++;
      $display("FAIL midread_vld got=%b want=1", rd_vld);
    end
    cpurst_b = 1'b0;
    #1;
    checks++;
    if (rd_vld !== 1'b0 || rd_data !== 54'h0 || rd_gnt !== 1'b0 || sram_a !== 8'h00 || sram_cen !== 1'b1 || busy !== INIT_EN) begin
      failures++;
      $display("FAIL midread_reset got vld=%b data=%h gnt=%b a=%h cen=%b busy=%b", rd_vld, rd_data, rd_gnt, sram_a, sram_cen, busy);
    end
    repeat (2) @(posedge forever_cpuclk);
    #1 cpurst_b = 1'b1;
    model_reset();
    test_init_sweep(INIT_EN ? 256 : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_init_sweep(INIT_EN ? 256 : 0);
    test_read_init();
    test_half_mask();
    test_arb_pattern();
    test_raw();
    test_random(400);
    test_flush();
`ifdef CT_SPSRAM_ARB_INIT_EN
    test_reset_mid_sweep();
`endif
    test_reset_mid_read();
    test_random(100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
